// File: rtl/approx_multiplier_sequencer_pkg.sv
// rtl/approx_multiplier_sequencer_pkg.sv - shared types, constants and step table for the 32x32 approximate multiply sequencer
package approx_multiplier_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] i;
    logic [1:0] j;
  } pair_t;

  localparam logic [6:0] EXACT_U   = 7'h7F;
  localparam logic [3:0] LAST_STEP = 4'd9;

  // Only byte pairs with i+j <= 3 reach bits [31:0] of the product.
  function automatic pair_t step_pair(input logic [3:0] step);
    pair_t p;
    case (step)
      4'd0:    p = '{i: 2'd0, j: 2'd0};
      4'd1:    p = '{i: 2'd0, j: 2'd1};
      4'd2:    p = '{i: 2'd0, j: 2'd2};
      4'd3:    p = '{i: 2'd0, j: 2'd3};
      4'd4:    p = '{i: 2'd1, j: 2'd0};
      4'd5:    p = '{i: 2'd1, j: 2'd1};
      4'd6:    p = '{i: 2'd1, j: 2'd2};
      4'd7:    p = '{i: 2'd2, j: 2'd0};
      4'd8:    p = '{i: 2'd2, j: 2'd1};
      4'd9:    p = '{i: 2'd3, j: 2'd0};
      default: p = '{i: 2'd0, j: 2'd0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/approx_multiplier_sequencer_if.sv
// rtl/approx_multiplier_sequencer_if.sv - execute-stage multiplier port between the pipeline and the sequencer
interface approx_multiplier_sequencer_if;
  logic        start;
  logic        flush;
  logic [31:0] input_1;
  logic [31:0] input_2;
  logic [7:0]  accuracy;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, flush, input_1, input_2, accuracy,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, input_1, input_2, accuracy,
    output busy, done, result
  );
endinterface

// File: rtl/approx_multiplier_sequencer_byte_pair_selector.sv
// rtl/approx_multiplier_sequencer_byte_pair_selector.sv - maps a step to array operand bytes and partial-product shift
module byte_pair_selector
  import approx_multiplier_sequencer_pkg::*;
(
  input  logic        en,
  input  logic [3:0]  step,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [7:0]  op1,
  output logic [7:0]  op2,
  output logic [4:0]  shift
);
  pair_t p;

  always_comb begin
    p     = step_pair(step);
    op1   = en ? a[8*p.i +: 8] : 8'h00;
    op2   = en ? b[8*p.j +: 8] : 8'h00;
    shift = {p.i + p.j, 3'b000};
  end
endmodule

// File: rtl/approx_multiplier_sequencer.sv
// rtl/approx_multiplier_sequencer.sv - low 32 bits of a 32x32 product over ten cycles of a shared 8x8 approximate array
module approx_multiplier_sequencer
  import approx_multiplier_sequencer_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  approx_multiplier_sequencer_if.slave        exe,
  output logic [7:0]                          mul_op1,
  output logic [7:0]                          mul_op2,
  output logic [6:0]                          mul_u,
  input  logic [15:0]                         mul_result
);
  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [6:0]  u_q, u_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic [4:0]  shift;
  logic        zero_op;

  byte_pair_selector u_sel (
    .en    (state_q == ST_MUL),
    .step  (step_q),
    .a     (a_q),
    .b     (b_q),
    .op1   (mul_op1),
    .op2   (mul_op2),
    .shift (shift)
  );

  assign mul_u       = (state_q == ST_MUL) ? u_q : EXACT_U;
  assign exe.busy    = (state_q == ST_MUL);
  assign exe.done    = done_q;
  assign exe.result  = result_q;
  assign zero_op     = (exe.input_1 == 32'h0) || (exe.input_2 == 32'h0);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    u_d      = u_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A flush arriving with start drops the request.
        if (exe.start && !exe.flush) begin
          if (ZERO_SKIP && zero_op) begin
            result_d = 32'h0;
            done_d   = 1'b1;
          end else begin
            state_d = ST_MUL;
            a_d     = exe.input_1;
            b_d     = exe.input_2;
            u_d     = exe.accuracy[7] ? EXACT_U : exe.accuracy[6:0];
            acc_d   = 32'h0;
            step_d  = 4'd0;
          end
        end
      end
      ST_MUL: begin
        if (exe.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = acc_q + ({16'h0, mul_result} << shift);
          step_d = step_q + 4'd1;
          if (step_q == LAST_STEP) begin
            result_d = acc_d;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      step_q   <= 4'd0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      u_q      <= EXACT_U;
      acc_q    <= 32'h0;
      result_q <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      u_q      <= u_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: doc/approx_multiplier_sequencer.md
Name: approx_multiplier_sequencer

Overview:
- Multi-cycle controller that produces the low 32 bits of a 32x32 product using one shared 8x8 error-configurable approximate multiplier, the Multiplier_ECA-style array.
- Splits both operands into bytes and issues the 10 byte-pair products that affect bits [31:0], one per cycle.
- Shifts and accumulates each partial product into a 32-bit register.
- Drives the 7-bit per-adder accuracy vector `u` of the array from the 8-bit `accuracy` input.
- Sits between the execute stage's multiplier port (`input_1`, `input_2`, `accuracy`, `busy`, `result`) and the combinational 8x8 array instance.

Parameters:
- `EXACT_U`, 7'h7F: `u` value that makes every error-configurable adder exact (M=1).
- `ZERO_SKIP`, 1: when 1, a zero operand completes in one cycle without using the array.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request, sampled only when idle.
- `flush` input 1: synchronous abort of the operation in flight.
- `input_1` input 32: multiplicand.
- `input_2` input 32: multiplier.
- `accuracy` input 8: bit 7 = force exact; bits [6:0] = `u` when bit 7 = 0.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle completion pulse.
- `result` output 32: low 32 bits of the accumulated product.
- `mul_op1` output 8: byte to array operand 1.
- `mul_op2` output 8: byte to array operand 2.
- `mul_u` output 7: accuracy vector to the array.
- `mul_result` input 16: combinational array product.

Behaviour:
- Reset (`reset`=0, asynchronous): state IDLE; `busy`, `done`, `result`, accumulator, step counter, `mul_op1`, `mul_op2` all 0; `mul_u` = `EXACT_U`.
- States: IDLE, MUL.
- IDLE to MUL: `start`=1 and not (`ZERO_SKIP` and (`input_1`==0 or `input_2`==0)).
  - Latch `A` = `input_1`, `B` = `input_2`.
  - Latch `U` = `accuracy[7]` ? `EXACT_U` : `accuracy[6:0]`.
  - Clear accumulator; step = 0.
- Zero early-out: same sampling edge, state stays IDLE; next cycle `result` = 0 and `done` = 1; `busy` never rises.
- Step order in MUL, step 0..9, pair (i,j) with i+j<=3:
  - (0,0) (0,1) (0,2) (0,3) (1,0) (1,1) (1,2) (2,0) (2,1) (3,0).
  - `mul_op1` = `A` byte i, `mul_op2` = `B` byte j; drive combinationally from step, zero in IDLE.
  - `mul_u` = `U` during MUL, `EXACT_U` otherwise.
- Each MUL edge: acc <= (acc + ({16'b0, `mul_result`} << 8*(i+j)))[31:0]. Arithmetic is modulo 2^32; overflow is silently discarded.
- Step 9 edge:
  - `result` <= final sum; `done` <= 1 for exactly one cycle.
  - State returns to IDLE; `busy` <= 0.
- Latency: `start` in cycle 0; `busy`=1 in cycles 1..10; `done` and the new `result` in cycle 11.
- `busy` is a registered output that is 1 exactly while in MUL.
- `start` while busy: ignored, not queued.
- `start` in the same cycle as `done`: accepted, since state is IDLE.
- `result` holds its value until the next completion. Flush and ignored starts never change it.
- `flush`=1 in MUL: next edge goes to IDLE, `busy`=0, no `done`, `result` unchanged.
- `flush`=1 in IDLE: no effect. `flush` has priority over `start` in the same cycle; the start is dropped.
- Reset mid-operation: immediate return to the reset values.
- Operands and accuracy are sampled only at acceptance; input changes during MUL have no effect.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=1'b0, MUL=1'b1);
  - `EXACT_U`;
  - the 10-entry step-to-(i,j) table as a constant function or localparam array.
- One sub-module: `byte_pair_selector`, combinational; step gives `mul_op1`, `mul_op2` and shift amount.
- The 8x8 array is instantiated by the parent, outside this block.

Test Plan:
- `input_1`=3, `input_2`=5, `accuracy`=8'h80: `busy` high cycles 1..10; `done` in cycle 11; `result`=15.
- Wrap-around:
  - 0xFFFFFFFF x 0xFFFFFFFF, exact → `result`=32'h00000001.
  - 0x00010000 x 0x00010000 → 0.
  - 0x00010000 x 0x00000100 → 32'h01000000.
- 0 x 0xDEADBEEF, `ZERO_SKIP`=1: `done` in cycle 1; `result`=0; `busy` stays 0; `mul_op1`/`mul_op2` stay 0.
- `flush` in cycle 5 of an operation: `busy`=0 in cycle 6; no `done`; `result` keeps the prior value (15). A new `start` in cycle 6 completes normally.
- `start` pulsed in cycles 3 and 7 during busy: ignored; only one `done`.
  - Back-to-back: `start` in the `done` cycle gives the next `done` 11 cycles later.
- `accuracy`=8'h00 and 8'h2A with random operands:
  - `mul_u` equals `accuracy[6:0]` in every MUL cycle;
  - `result` matches the bit-accurate ECA golden model summed over the 10 pairs.
  - Mid-operation asynchronous reset clears all outputs immediately.
